// File: rtl/hmmm_alu_pkg.sv
// Shared definitions for the Hmmm arithmetic sequencer: op codes, state
// encoding and default widths.
package hmmm_alu_pkg;

    localparam int DW_DEF     = 16;
    localparam int REG_AW_DEF = 4;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_MUL    = 3'd2;
    localparam logic [2:0] ALU_DIV    = 3'd3;
    localparam logic [2:0] ALU_MOD    = 3'd4;
    localparam logic [2:0] ALU_OP_MAX = ALU_MOD;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ_A = 3'd1;
    localparam logic [2:0] ST_READ_B = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == ALU_DIV) || (op == ALU_MOD);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer driving an external 16-bit ALU for one Hmmm arithmetic
// instruction: operand fetch, execute, write-back, flag update.
//
// state   | meaning
// IDLE    | ready for a request; latch fields on req_valid
// READ_A  | read rs into tmp1
// READ_B  | read rt (or sign-extended imm) into tmp2
// EXEC    | enable ALU and capture result/flags, or report an error
// WRITE   | write result to rd (suppressed for r0), pulse done
module alu_sequencer
    import hmmm_alu_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [REG_AW-1:0] req_rd,
    input  logic [REG_AW-1:0] req_rs,
    input  logic [REG_AW-1:0] req_rt,
    input  logic              req_imm_en,
    input  logic [7:0]        req_imm,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DW-1:0]     rf_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [DW-1:0]     alu_tmp1,
    output logic [DW-1:0]     alu_tmp2,
    output logic [2:0]        alu_op,
    output logic              alu_enable,
    input  logic [DW-1:0]     alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_sign,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_sign,
    output logic              done,
    output logic              err_div0,
    output logic              err_illegal
);

    logic [2:0]        state_q;
    logic [2:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic              imm_en_q;
    logic [7:0]        imm_q;
    logic [DW-1:0]     tmp1_q;
    logic [DW-1:0]     tmp2_q;
    logic [DW-1:0]     result_q;
    logic [DW-1:0]     imm_ext;
    logic              in_exec;
    logic              illegal_op;
    logic              div_zero;
    logic              exec_err;

    assign imm_ext    = {{(DW-8){imm_q[7]}}, imm_q};
    assign in_exec    = (state_q == ST_EXEC);
    assign illegal_op = (op_q > ALU_OP_MAX);
    assign div_zero   = is_div_op(op_q) && (tmp2_q == '0);
    assign exec_err   = illegal_op || div_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            imm_en_q   <= 1'b0;
            imm_q      <= '0;
            tmp1_q     <= '0;
            tmp2_q     <= '0;
            result_q   <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_sign  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        rd_q     <= req_rd;
                        rs_q     <= req_rs;
                        rt_q     <= req_rt;
                        imm_en_q <= req_imm_en;
                        imm_q    <= req_imm;
                        state_q  <= ST_READ_A;
                    end
                end
                ST_READ_A: begin
                    tmp1_q  <= rf_rdata;
                    state_q <= ST_READ_B;
                end
                ST_READ_B: begin
                    tmp2_q  <= imm_en_q ? imm_ext : rf_rdata;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Errors complete here and leave result and flags untouched.
                    if (exec_err) begin
                        state_q <= ST_IDLE;
                    end else begin
                        result_q   <= alu_result;
                        flag_zero  <= alu_zero;
                        flag_carry <= alu_carry;
                        flag_sign  <= alu_sign;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rf_raddr = '0;
        if (state_q == ST_READ_A) begin
            rf_raddr = rs_q;
        end else if (state_q == ST_READ_B) begin
            rf_raddr = rt_q;
        end
    end

    // Gated with reset so every output reads 0 while reset is held.
    assign req_ready   = (state_q == ST_IDLE) && !reset;
    assign rf_we       = (state_q == ST_WRITE) && (rd_q != '0);
    assign rf_waddr    = rd_q;
    assign rf_wdata    = result_q;
    assign alu_tmp1    = tmp1_q;
    assign alu_tmp2    = tmp2_q;
    assign alu_op      = op_q;
    assign alu_enable  = in_exec && !exec_err;
    assign err_illegal = in_exec && illegal_op;
    assign err_div0    = in_exec && !illegal_op && div_zero;
    assign done        = (in_exec && exec_err) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: register file and ALU stand-ins,
// directed scenarios and randomized instructions against a behavioural model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [3:0]  req_rd, req_rs, req_rt;
    logic        req_imm_en;
    logic [7:0]  req_imm;
    logic [3:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_tmp1, alu_tmp2;
    logic [2:0]  alu_op;
    logic        alu_enable;
    logic [15:0] alu_result;
    logic        alu_zero, alu_carry, alu_sign;
    logic        flag_zero, flag_carry, flag_sign;
    logic        done, err_div0, err_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] rf_mem [16];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt),
        .req_imm_en(req_imm_en), .req_imm(req_imm),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_tmp1(alu_tmp1), .alu_tmp2(alu_tmp2), .alu_op(alu_op), .alu_enable(alu_enable),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_sign(flag_sign),
        .done(done), .err_div0(err_div0), .err_illegal(err_illegal)
    );

    // Arithmetic rules on plain integers: {carry(signed overflow), result}.
    function automatic logic [16:0] arith(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int ai, bi, r;
        logic [15:0] r16;
        ai = $signed(a);
        bi = $signed(b);
        case (op)
            3'd0: r = ai + bi;
            3'd1: r = ai - bi;
            3'd2: r = ai * bi;
            3'd3: r = (bi == 0) ? 0 : ai / bi;
            3'd4: r = (bi == 0) ? 0 : ai % bi;
            default: r = 0;
        endcase
        r16 = r[15:0];
        return {(r > 32767) || (r < -32768), r16};
    endfunction

    assign rf_rdata = (rf_raddr == 4'd0) ? 16'h0000 : rf_mem[rf_raddr];
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] = rf_wdata;

    logic [16:0] alu_full;
    assign alu_full   = arith(alu_op, alu_tmp1, alu_tmp2);
    assign alu_result = alu_full[15:0];
    assign alu_carry  = alu_full[16];
    assign alu_zero   = (alu_full[15:0] == 16'h0000);
    assign alu_sign   = alu_full[15];

    // Result of one instruction observed over six cycles after acceptance.
    int          o_done, o_we, o_e0, o_ei;
    logic [3:0]  o_wa;
    logic [15:0] o_wd;
    logic        o_rdy3;

    // Caller must be at a negedge with the sequencer idle.
    task automatic run_instr(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs,
                             input logic [3:0] rt, input logic ie, input logic [7:0] imm);
        req_valid = 1'b1; req_op = op; req_rd = rd; req_rs = rs; req_rt = rt;
        req_imm_en = ie; req_imm = imm;
        o_done = -1; o_we = -1; o_e0 = -1; o_ei = -1; o_wa = '0; o_wd = '0; o_rdy3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (done && o_done < 0) o_done = k;
            if (rf_we && o_we < 0) begin o_we = k; o_wa = rf_waddr; o_wd = rf_wdata; end
            if (err_div0 && o_e0 < 0) o_e0 = k;
            if (err_illegal && o_ei < 0) o_ei = k;
            if (k == 4) o_rdy3 = req_ready;
            // Garbage on the request bus mid-operation must be ignored.
            if (k < 3) begin
                req_valid = 1'b1; req_op = 3'($urandom); req_rd = 4'($urandom);
                req_rs = 4'($urandom); req_rt = 4'($urandom);
                req_imm_en = 1'($urandom); req_imm = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs = '0; req_rt = '0;
        req_imm_en = 1'b0; req_imm = '0;
        for (int i = 0; i < 16; i++) rf_mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_checks++; if ({done, rf_we, alu_enable, err_div0, err_illegal} !== 5'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 00000", {done, rf_we, alu_enable, err_div0, err_illegal}); end
        n_checks++; if ({flag_zero, flag_carry, flag_sign} !== 3'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {flag_zero, flag_carry, flag_sign}); end
        n_checks++; if ({alu_tmp1, alu_tmp2, rf_wdata, rf_raddr, rf_waddr, alu_op} !== '0) begin
            n_fail++; $display("FAIL reset_data: got nonzero data outputs"); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_add;
        rf_mem[1] = 16'd3; rf_mem[2] = 16'd2;
        run_instr(3'd0, 4'd3, 4'd1, 4'd2, 1'b0, 8'h00);
        n_checks++; if (o_done !== 4) begin n_fail++; $display("FAIL add_done_cycle: got %0d want 4", o_done); end
        n_checks++; if (o_we !== 4 || o_wa !== 4'd3 || o_wd !== 16'd5) begin
            n_fail++; $display("FAIL add_write: got cyc=%0d addr=%0d data=%h want 4/3/0005", o_we, o_wa, o_wd); end
        n_checks++; if ({flag_zero, flag_carry, flag_sign} !== 3'b000) begin
            n_fail++; $display("FAIL add_flags: got %b want 000", {flag_zero, flag_carry, flag_sign}); end
        n_checks++; if (rf_mem[3] !== 16'd5) begin n_fail++; $display("FAIL add_rf: got %h want 0005", rf_mem[3]); end
    endtask

    task automatic test_overflow_sub;
        rf_mem[1] = 16'd32767; rf_mem[2] = 16'd2;
        run_instr(3'd0, 4'd4, 4'd1, 4'd2, 1'b0, 8'h00);
        n_checks++; if (o_we !== 4 || o_wa !== 4'd4 || o_wd !== 16'h8001) begin
            n_fail++; $display("FAIL ovf_write: got cyc=%0d addr=%0d data=%h want 4/4/8001", o_we, o_wa, o_wd); end
        n_checks++; if ({flag_zero, flag_carry, flag_sign} !== 3'b011) begin
            n_fail++; $display("FAIL ovf_flags: got zcs=%b want 011", {flag_zero, flag_carry, flag_sign}); end
        rf_mem[1] = 16'hFFF9; rf_mem[2] = 16'hFFF9;
        run_instr(3'd1, 4'd7, 4'd1, 4'd2, 1'b0, 8'h00);
        n_checks++; if (o_we !== 4 || o_wd !== 16'h0000) begin
            n_fail++; $display("FAIL sub_write: got cyc=%0d data=%h want 4/0000", o_we, o_wd); end
        n_checks++; if ({flag_zero, flag_carry, flag_sign} !== 3'b100) begin
            n_fail++; $display("FAIL sub_flags: got zcs=%b want 100", {flag_zero, flag_carry, flag_sign}); end
    endtask

    task automatic test_mod_div;
        rf_mem[1] = 16'hFFF4; rf_mem[2] = 16'd5;
        run_instr(3'd4, 4'd5, 4'd1, 4'd2, 1'b0, 8'h00);
        n_checks++; if (o_we !== 4 || o_wa !== 4'd5 || o_wd !== 16'hFFFE) begin
            n_fail++; $display("FAIL mod_write: got cyc=%0d addr=%0d data=%h want 4/5/fffe", o_we, o_wa, o_wd); end
        rf_mem[1] = 16'd15;
        run_instr(3'd3, 4'd8, 4'd1, 4'd2, 1'b1, 8'hFD);
        n_checks++; if (o_we !== 4 || o_wa !== 4'd8 || o_wd !== 16'hFFFB) begin
            n_fail++; $display("FAIL divimm_write: got cyc=%0d addr=%0d data=%h want 4/8/fffb", o_we, o_wa, o_wd); end
        n_checks++; if ({flag_zero, flag_carry, flag_sign} !== 3'b001) begin
            n_fail++; $display("FAIL divimm_flags: got zcs=%b want 001", {flag_zero, flag_carry, flag_sign}); end
    endtask

    task automatic test_div0;
        rf_mem[1] = 16'd15; rf_mem[2] = 16'd0; rf_mem[6] = 16'h1234;
        run_instr(3'd3, 4'd6, 4'd1, 4'd2, 1'b0, 8'h00);
        n_checks++; if (o_done !== 3 || o_e0 !== 3 || o_ei !== -1) begin
            n_fail++; $display("FAIL div0_pulses: got done=%0d div0=%0d ill=%0d want 3/3/-1", o_done, o_e0, o_ei); end
        n_checks++; if (o_we !== -1 || rf_mem[6] !== 16'h1234) begin
            n_fail++; $display("FAIL div0_nowrite: got we_cyc=%0d r6=%h want -1/1234", o_we, rf_mem[6]); end
        n_checks++; if ({flag_zero, flag_carry, flag_sign} !== 3'b001) begin
            n_fail++; $display("FAIL div0_flags: got zcs=%b want 001", {flag_zero, flag_carry, flag_sign}); end
        n_checks++; if (o_rdy3 !== 1'b1) begin n_fail++; $display("FAIL div0_ready_t3: got %b want 1", o_rdy3); end
    endtask

    task automatic test_illegal_r0;
        run_instr(3'd6, 4'd9, 4'd1, 4'd2, 1'b0, 8'h00);
        n_checks++; if (o_done !== 3 || o_ei !== 3 || o_e0 !== -1 || o_we !== -1) begin
            n_fail++; $display("FAIL illegal: got done=%0d ill=%0d div0=%0d we=%0d want 3/3/-1/-1", o_done, o_ei, o_e0, o_we); end
        n_checks++; if ({flag_zero, flag_carry, flag_sign} !== 3'b001) begin
            n_fail++; $display("FAIL illegal_flags: got zcs=%b want 001", {flag_zero, flag_carry, flag_sign}); end
        rf_mem[1] = 16'd3; rf_mem[2] = 16'd2;
        run_instr(3'd0, 4'd0, 4'd1, 4'd2, 1'b0, 8'h00);
        n_checks++; if (o_we !== -1 || o_done !== 4) begin
            n_fail++; $display("FAIL r0_write: got we=%0d done=%0d want -1/4", o_we, o_done); end
        n_checks++; if ({flag_zero, flag_carry, flag_sign} !== 3'b000) begin
            n_fail++; $display("FAIL r0_flags: got zcs=%b want 000", {flag_zero, flag_carry, flag_sign}); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        rf_mem[1] = 16'd3; rf_mem[2] = 16'd5;
        run_instr(3'd1, 4'd10, 4'd1, 4'd2, 1'b0, 8'h00);
        rf_mem[2] = 16'hFFFE; rf_mem[9] = 16'hBEEF;
        req_valid = 1'b1; req_op = 3'd2; req_rd = 4'd9; req_rs = 4'd1; req_rt = 4'd2; req_imm_en = 1'b0;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (alu_enable !== 1'b1 || {flag_zero, flag_carry, flag_sign} !== 3'b001) begin
            n_fail++; $display("FAIL mid_exec: got en=%b zcs=%b want 1/001", alu_enable, {flag_zero, flag_carry, flag_sign}); end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        if (rf_we || done) seen = 1'b1;
        n_checks++; if (seen !== 1'b0 || rf_mem[9] !== 16'hBEEF) begin
            n_fail++; $display("FAIL mid_abort: got we_or_done=%b r9=%h want 0/beef", seen, rf_mem[9]); end
        n_checks++; if ({flag_zero, flag_carry, flag_sign} !== 3'b000 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_after: got zcs=%b ready=%b want 000/1", {flag_zero, flag_carry, flag_sign}, req_ready); end
        run_instr(3'd2, 4'd11, 4'd1, 4'd2, 1'b0, 8'h00);
        n_checks++; if (o_we !== 4 || o_wa !== 4'd11 || o_wd !== 16'hFFFA) begin
            n_fail++; $display("FAIL mid_next: got cyc=%0d addr=%0d data=%h want 4/11/fffa", o_we, o_wa, o_wd); end
    endtask

    task automatic test_back_to_back;
        rf_mem[1] = 16'd100; rf_mem[2] = 16'd7;
        run_instr(3'd2, 4'd12, 4'd1, 4'd2, 1'b0, 8'h00);
        run_instr(3'd1, 4'd13, 4'd12, 4'd2, 1'b0, 8'h00);
        n_checks++; if (o_we !== 4 || o_wa !== 4'd13 || o_wd !== 16'd693) begin
            n_fail++; $display("FAIL b2b_dep: got cyc=%0d addr=%0d data=%h want 4/13/02b5", o_we, o_wa, o_wd); end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [3:0]  rd, rs, rt;
        logic        ie;
        logic [7:0]  imm;
        logic [15:0] a, b;
        logic [16:0] r;
        logic [2:0]  ef;
        rf_mem[1] = 16'd3; rf_mem[2] = 16'd2;
        run_instr(3'd0, 4'd0, 4'd1, 4'd2, 1'b0, 8'h00);
        ef = 3'b000;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7)); rd = 4'($urandom); rs = 4'($urandom); rt = 4'($urandom);
            ie = ($urandom_range(0, 3) == 0); imm = 8'($urandom);
            if (rt != 0) rf_mem[rt] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            if (rs != 0) rf_mem[rs] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 40)) - 16'd20 : 16'($urandom);
            a = (rs == 0) ? 16'h0000 : rf_mem[rs];
            b = ie ? {{8{imm[7]}}, imm} : ((rt == 0) ? 16'h0000 : rf_mem[rt]);
            r = arith(op, a, b);
            run_instr(op, rd, rs, rt, ie, imm);
            if (op > 3'd4) begin
                n_checks++; if (o_done !== 3 || o_ei !== 3 || o_e0 !== -1 || o_we !== -1) begin
                    n_fail++; $display("FAIL rnd_illegal[%0d]: got done=%0d ill=%0d div0=%0d we=%0d", i, o_done, o_ei, o_e0, o_we); end
            end else if ((op == 3'd3 || op == 3'd4) && b == 16'h0000) begin
                n_checks++; if (o_done !== 3 || o_e0 !== 3 || o_ei !== -1 || o_we !== -1) begin
                    n_fail++; $display("FAIL rnd_div0[%0d]: got done=%0d div0=%0d ill=%0d we=%0d", i, o_done, o_e0, o_ei, o_we); end
            end else begin
                ef = {(r[15:0] == 16'h0000), r[16], r[15]};
                n_checks++; if (o_done !== 4 || o_e0 !== -1 || o_ei !== -1) begin
                    n_fail++; $display("FAIL rnd_done[%0d]: got done=%0d div0=%0d ill=%0d want 4", i, o_done, o_e0, o_ei); end
                n_checks++;
                if (rd == 0 ? (o_we !== -1) : (o_we !== 4 || o_wa !== rd || o_wd !== r[15:0])) begin
                    n_fail++; $display("FAIL rnd_write[%0d]: op=%0d got cyc=%0d addr=%0d data=%h want rd=%0d data=%h",
                                       i, op, o_we, o_wa, o_wd, rd, r[15:0]); end
            end
            n_checks++; if ({flag_zero, flag_carry, flag_sign} !== ef) begin
                n_fail++; $display("FAIL rnd_flags[%0d]: op=%0d got zcs=%b want %b", i, op, {flag_zero, flag_carry, flag_sign}, ef); end
        end
    endtask

    initial begin
        test_reset;
        @(negedge clk);
        test_add;
        test_overflow_sub;
        test_mod_div;
        test_div0;
        test_illegal_r0;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
